// File: rtl/mac_pkt_gen.sv
// mac_pkt_gen: traffic source for the teng_mac user TX stream; frame length sweeps LEN_MIN..LEN_MAX, payload is deterministic.
// Latency: first beat is valid one clock after start_i is sampled; IPG_CYCLES idle clocks separate frames.
// Backpressure: a presented beat holds until tx_ready_i; a new frame waits while MAX_OUTST frames lack a response.
// Build option MAC_PKT_GEN_PRBS_EN: payload is PRBS-31 (x^31+x^28+1) instead of an incrementing byte counter.
module mac_pkt_gen #(
  parameter int LEN_MIN    = 60,
  parameter int LEN_MAX    = 1514,
  parameter int LEN_STEP   = 1,
  parameter int IPG_CYCLES = 4,
  parameter int MAX_OUTST  = 8
) (
  input  logic        s_user_clk,
  input  logic        r_global_rst,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [15:0] num_pkts_i,
  output logic [31:0] tx_data_o,
  output logic [3:0]  tx_vldb_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        tx_last_o,
  output logic        tx_user_o,
  input  logic        tx_status_i,
  input  logic        tx_rsp_valid_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] sent_cnt_o,
  output logic [15:0] ok_cnt_o,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Last value of the gap counter before the FSM leaves GAP.
  localparam logic [15:0] GAP_LAST = (IPG_CYCLES == 0) ? 16'd0 : 16'(IPG_CYCLES - 1);

  state_t      state;
  logic [15:0] len;          // length of the frame in flight (or just finished)
  logic [15:0] rem;          // bytes of the current frame not yet presented
  logic [15:0] pkts_target;  // frames requested for this run, 0 = continuous
  logic [15:0] gap_cnt;
  logic [7:0]  outst;        // frames accepted but not yet answered
  logic        stop_pend;

  logic        frame_done;
  logic [16:0] len_sum;
  logic [15:0] len_nx;
  logic [7:0]  outst_nx;
  logic [15:0] sent_nx;
  logic        can_send;
  logic        stop_now;
  logic        due;
  logic        gap_end;
  logic        decide;
  logic        load;

  logic [15:0] src_rem;
  logic [2:0]  beat_n;
  logic [3:0]  beat_vldb;
  logic        beat_last;
  logic [15:0] rem_after;
  logic [31:0] beat_data;

  assign tx_user_o = 1'b0;

  // Frame accounting and the decision of whether a beat is loaded this clock.
  always_comb begin
    frame_done = tx_valid_o & tx_ready_i & tx_last_o;
    len_sum    = {1'b0, len} + 17'(LEN_STEP);
    len_nx     = (len_sum > 17'(LEN_MAX)) ? 16'(LEN_MIN) : len_sum[15:0];
    case ({frame_done, tx_rsp_valid_i})
      2'b10:   outst_nx = outst + 8'd1;
      2'b01:   outst_nx = (outst == 8'd0) ? 8'd0 : outst - 8'd1;
      default: outst_nx = outst;
    endcase
    sent_nx  = sent_cnt_o + {15'd0, frame_done};
    can_send = (outst_nx < 8'(MAX_OUTST));
    stop_now = stop_pend | stop_i;
    due      = !stop_now && ((pkts_target == 16'd0) || (sent_nx < pkts_target));
    gap_end  = (state == GAP) && (gap_cnt == GAP_LAST);
    // With no inter-packet gap the next-frame decision is taken on the last-beat accept itself.
    decide   = ((state == SEND) && frame_done && (IPG_CYCLES == 0)) || gap_end;
    load     = ((state == IDLE) && start_i) ||
               ((state == SEND) && !tx_valid_o && can_send) ||
               ((state == SEND) && tx_valid_o && tx_ready_i && !tx_last_o) ||
               (decide && due && can_send);
  end

  // Shape of the next beat: byte count, enables and end-of-frame flag.
  always_comb begin
    if (state == IDLE) begin
      src_rem = 16'(LEN_MIN);
    end else if (frame_done) begin
      src_rem = len_nx;
    end else begin
      src_rem = rem;
    end
    beat_n = (src_rem >= 16'd4) ? 3'd4 : src_rem[2:0];
    case (beat_n)
      3'd1:    beat_vldb = 4'h1;
      3'd2:    beat_vldb = 4'h3;
      3'd3:    beat_vldb = 4'h7;
      default: beat_vldb = 4'hF;
    endcase
    beat_last = (src_rem <= 16'd4);
    rem_after = src_rem - {13'd0, beat_n};
  end

`ifdef MAC_PKT_GEN_PRBS_EN
  logic [30:0] prbs;
  logic [30:0] src_prbs;
  logic [30:0] prbs_after;
  logic [31:0] prbs_word;

  // 32 PRBS-31 bits per beat, first generated bit lands in byte0 bit0; masked bytes still use their bits.
  always_comb begin : prbs_gen
    logic [30:0] p;
    logic        fb;
    src_prbs  = (state == IDLE) ? 31'h7FFF_FFFF : prbs;
    p         = src_prbs;
    fb        = 1'b0;
    prbs_word = '0;
    for (int i = 0; i < 32; i++) begin
      fb           = p[30] ^ p[27];
      prbs_word[i] = fb;
      p            = {p[29:0], fb};
    end
    prbs_after = p;
    beat_data  = prbs_word & {{8{beat_vldb[3]}}, {8{beat_vldb[2]}}, {8{beat_vldb[1]}}, {8{beat_vldb[0]}}};
  end

  // PRBS state advances once per loaded beat and restarts from the seed on start.
  always_ff @(posedge s_user_clk or negedge r_global_rst) begin
    if (!r_global_rst) begin
      prbs <= 31'h7FFF_FFFF;
    end else if (load) begin
      prbs <= prbs_after;
    end
  end
`else
  logic [7:0] byte_cnt;
  logic [7:0] src_cnt;
  logic [7:0] cnt_after;

  // Payload bytes continue the run byte counter; unused lanes stay zero.
  always_comb begin
    src_cnt   = (state == IDLE) ? 8'd0 : byte_cnt;
    beat_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(beat_n)) begin
        beat_data[8*i +: 8] = src_cnt + 8'(i);
      end
    end
    cnt_after = src_cnt + {5'd0, beat_n};
  end

  // Run byte counter advances by the number of real bytes in each loaded beat.
  always_ff @(posedge s_user_clk or negedge r_global_rst) begin
    if (!r_global_rst) begin
      byte_cnt <= 8'd0;
    end else if (load) begin
      byte_cnt <= cnt_after;
    end
  end
`endif

  // Control FSM with registered stream outputs, status flags and counters.
  always_ff @(posedge s_user_clk or negedge r_global_rst) begin
    if (!r_global_rst) begin
      state       <= IDLE;
      len         <= 16'(LEN_MIN);
      rem         <= 16'(LEN_MIN);
      pkts_target <= 16'd0;
      gap_cnt     <= 16'd0;
      outst       <= 8'd0;
      stop_pend   <= 1'b0;
      tx_data_o   <= 32'd0;
      tx_vldb_o   <= 4'd0;
      tx_valid_o  <= 1'b0;
      tx_last_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      sent_cnt_o  <= 16'd0;
      ok_cnt_o    <= 16'd0;
      err_cnt_o   <= 16'd0;
    end else begin
      done_o <= 1'b0;
      outst  <= outst_nx;

      if (frame_done) begin
        sent_cnt_o <= sent_nx;
        len        <= len_nx;
        rem        <= len_nx;
      end

      if (tx_rsp_valid_i) begin
        if (tx_status_i) begin
          ok_cnt_o <= ok_cnt_o + 16'd1;
        end else begin
          err_cnt_o <= err_cnt_o + 16'd1;
        end
      end

      if (load) begin
        tx_valid_o <= 1'b1;
        tx_data_o  <= beat_data;
        tx_vldb_o  <= beat_vldb;
        tx_last_o  <= beat_last;
        rem        <= rem_after;
      end else if (tx_valid_o && tx_ready_i) begin
        tx_valid_o <= 1'b0;
        tx_data_o  <= 32'd0;
        tx_vldb_o  <= 4'd0;
        tx_last_o  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state       <= SEND;
            len         <= 16'(LEN_MIN);
            pkts_target <= num_pkts_i;
            stop_pend   <= 1'b0;
            sent_cnt_o  <= 16'd0;
            ok_cnt_o    <= 16'd0;
            err_cnt_o   <= 16'd0;
            busy_o      <= 1'b1;
          end
        end
        SEND: begin
          if (stop_i) begin
            stop_pend <= 1'b1;
          end
          if (frame_done) begin
            if (IPG_CYCLES == 0) begin
              state <= due ? SEND : DRAIN;
            end else begin
              state   <= GAP;
              gap_cnt <= 16'd0;
            end
          end
        end
        GAP: begin
          if (stop_i) begin
            stop_pend <= 1'b1;
          end
          if (gap_end) begin
            state <= due ? SEND : DRAIN;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        DRAIN: begin
          if (outst_nx == 8'd0) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_pkt_gen.sv
// tb_mac_pkt_gen: scoreboard bench for mac_pkt_gen with a frame/byte-stream reference model.
// Latency: expects the first beat one clock after start and IPG idle clocks between frames.
// Backpressure: drives random tx_ready and a randomly delayed, alternating-status response stream.
module tb_mac_pkt_gen;

  localparam int LEN_MIN   = 60;
  localparam int LEN_MAX   = 63;
  localparam int LEN_STEP  = 1;
  localparam int IPG       = 4;
  localparam int MAX_OUTST = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] num_pkts;
  logic [31:0] tx_data;
  logic [3:0]  tx_vldb;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic        tx_user;
  logic        rsp_status;
  logic        rsp_valid;
  logic        busy;
  logic        done;
  logic [15:0] sent_cnt;
  logic [15:0] ok_cnt;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  mac_pkt_gen #(
    .LEN_MIN(LEN_MIN), .LEN_MAX(LEN_MAX), .LEN_STEP(LEN_STEP),
    .IPG_CYCLES(IPG), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .s_user_clk(clk), .r_global_rst(rst_n), .start_i(start), .stop_i(stop),
    .num_pkts_i(num_pkts), .tx_data_o(tx_data), .tx_vldb_o(tx_vldb),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_last_o(tx_last),
    .tx_user_o(tx_user), .tx_status_i(rsp_status), .tx_rsp_valid_i(rsp_valid),
    .busy_o(busy), .done_o(done), .sent_cnt_o(sent_cnt), .ok_cnt_o(ok_cnt),
    .err_cnt_o(err_cnt)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  v;
    logic        l;
  } beat_t;

  beat_t exp_q[$];

  int total = 0;
  int passed = 0;

  // Stimulus-side knobs (written only by the main process).
  logic ready_rand = 1'b0;
  logic rsp_en     = 1'b0;
  logic ipg_chk    = 1'b0;
  int   manual_cnt = 0;
  int   rsp_base   = 0;
  int   ok_base    = 0;
  int   err_base   = 0;
  int   done_base  = 0;

  // Monitor-owned state.
  int   frames_seen = 0;
  int   done_cnt    = 0;
  // Responder-owned state.
  int   rsp_cnt     = 0;
  int   manual_done = 0;
  int   ok_tot      = 0;
  int   err_tot     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Reference model: whole run as a byte stream cut into frames of the swept lengths.
  task automatic push_run(input int nframes);
    int          len;
    int          nbeats;
    int          nb;
    logic [7:0]  b;
    logic [31:0] w;
    logic [30:0] lfsr;
    logic        fb;
    beat_t       e;
    len  = LEN_MIN;
    b    = 8'd0;
    lfsr = 31'h7FFF_FFFF;
    for (int f = 0; f < nframes; f++) begin
      nbeats = (len + 3) / 4;
      for (int k = 0; k < nbeats; k++) begin
        nb  = (len - 4 * k >= 4) ? 4 : len - 4 * k;
        e.d = '0;
        e.v = '0;
        e.l = (k == nbeats - 1);
        w   = '0;
        for (int i = 0; i < 32; i++) begin
          fb   = lfsr[30] ^ lfsr[27];
          w[i] = fb;
          lfsr = {lfsr[29:0], fb};
        end
        for (int i = 0; i < nb; i++) begin
          e.v[i] = 1'b1;
`ifdef MAC_PKT_GEN_PRBS_EN
          e.d[8*i +: 8] = w[8*i +: 8];
`else
          e.d[8*i +: 8] = b;
`endif
          b = b + 8'd1;
        end
        exp_q.push_back(e);
      end
      len = len + LEN_STEP;
      if (len > LEN_MAX) len = LEN_MIN;
    end
  endtask

  // Ready driver and response generator; responses follow accepted frames.
  initial begin
    tx_ready   = 1'b1;
    rsp_valid  = 1'b0;
    rsp_status = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready   = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      rsp_valid  = 1'b0;
      rsp_status = 1'b0;
      if (!rst_n) begin
        rsp_cnt = 0;
      end else if ((frames_seen - rsp_cnt) > 0 &&
                   ((manual_cnt != manual_done) || (rsp_en && $urandom_range(0, 2) == 0))) begin
        rsp_valid  = 1'b1;
        rsp_status = (((rsp_cnt - rsp_base) % 2) == 0);
        if (rsp_status) ok_tot++; else err_tot++;
        rsp_cnt++;
        if (manual_cnt != manual_done) manual_done++;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stream rules.
  initial begin
    beat_t       e;
    logic        stall_prev = 1'b0;
    logic        in_frame   = 1'b0;
    logic        gap_armed  = 1'b0;
    logic        busy_prev  = 1'b0;
    int          gap_idle   = 0;
    logic [31:0] pd;
    logic [3:0]  pv;
    logic        pl;
    pd = '0; pv = '0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev  = 1'b0;
        in_frame    = 1'b0;
        gap_armed   = 1'b0;
        busy_prev   = 1'b0;
        frames_seen = 0;
      end else begin
        if (start) gap_armed = 1'b0;
        if (in_frame) chk("valid_held_mid_frame", tx_valid, 1);
        if (stall_prev) begin
          chk("stall_valid", tx_valid, 1);
          chk("stall_data", tx_data, pd);
          chk("stall_vldb", tx_vldb, pv);
          chk("stall_last", tx_last, pl);
        end
        if (tx_valid) chk("user_zero", tx_user, 0);
        if (gap_armed) begin
          if (!tx_valid) begin
            gap_idle++;
          end else begin
            if (ipg_chk) chk("ipg_cycles", gap_idle, IPG);
            gap_armed = 1'b0;
          end
        end
        if (done) begin
          done_cnt++;
          chk("busy_low_with_done", busy, 0);
          chk("busy_high_before_done", busy_prev, 1);
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_beat: got data 0x%0h, want no beat", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", tx_data, e.d);
            chk("beat_vldb", tx_vldb, e.v);
            chk("beat_last", tx_last, e.l);
          end
          in_frame = !tx_last;
          if (tx_last) begin
            frames_seen++;
            gap_armed = 1'b1;
            gap_idle  = 0;
          end
        end
        stall_prev = tx_valid && !tx_ready;
        pd = tx_data; pv = tx_vldb; pl = tx_last;
        busy_prev = busy;
      end
    end
  end

  task automatic start_run(input logic [15:0] n, input int nframes);
    push_run(nframes);
    ok_base   = ok_tot;
    err_base  = err_tot;
    rsp_base  = rsp_cnt;
    done_base = done_cnt;
    @(posedge clk); #1;
    num_pkts = n;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("first_beat_latency", tx_valid, 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt > done_base) break;
    end
    chk(name, (done_cnt > done_base), 1);
    repeat (3) @(negedge clk);
    #1;
    chk("done_single_pulse", done_cnt - done_base, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    num_pkts = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_vldb", tx_vldb, 0);
    chk("rst_last", tx_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnts", {sent_cnt, ok_cnt | err_cnt}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three frames, ready always high, responses on.
    rsp_en  = 1'b1;
    ipg_chk = 1'b1;
    start_run(16'd3, 3);
    wait_done("t1_done", 2000);
    chk("t1_sent", sent_cnt, 3);
    chk("t1_ok", ok_cnt, ok_tot - ok_base);
    chk("t1_err", err_cnt, err_tot - err_base);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_busy", busy, 0);

    // Same run with random backpressure; byte stream must be identical.
    ready_rand = 1'b1;
    start_run(16'd3, 3);
    wait_done("t2_done", 4000);
    chk("t2_sent", sent_cnt, 3);
    chk("t2_queue_empty", exp_q.size(), 0);
    ready_rand = 1'b0;
    ipg_chk    = 1'b0;

    // Outstanding throttle: no responses, 20 frames requested.
    rsp_en = 1'b0;
    start_run(16'd20, 20);
    repeat (300) @(negedge clk);
    #1;
    chk("t3_sent_at_limit", sent_cnt, MAX_OUTST);
    chk("t3_valid_stalled", tx_valid, 0);
    chk("t3_busy", busy, 1);
    manual_cnt++;
    repeat (200) @(negedge clk);
    #1;
    chk("t3_one_released", sent_cnt, MAX_OUTST + 1);
    chk("t3_valid_stalled_again", tx_valid, 0);
    rsp_en = 1'b1;
    wait_done("t3_done", 8000);
    chk("t3_sent", sent_cnt, 20);
    chk("t4_ok", ok_cnt, 10);
    chk("t4_err", err_cnt, 10);
    chk("t3_queue_empty", exp_q.size(), 0);

    // Length wrap: 60,61,62,63,60.
    start_run(16'd5, 5);
    wait_done("t5_done", 3000);
    chk("t5_sent", sent_cnt, 5);
    chk("t5_queue_empty", exp_q.size(), 0);

    // Continuous run stopped during frame 2; a start while busy is ignored.
    begin
      int i;
      start_run(16'd0, 2);
      for (i = 0; i < 400; i++) begin
        @(negedge clk); #1;
        if (sent_cnt == 16'd1 && tx_valid) break;
      end
      chk("t5_reached_frame2", (sent_cnt == 16'd1 && tx_valid), 1);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      wait_done("t5_stop_done", 3000);
      chk("t5_stop_sent", sent_cnt, 2);
      chk("t5_stop_queue_empty", exp_q.size(), 0);
    end

    // Asynchronous reset in the middle of frame 2, then a fresh run.
    start_run(16'd3, 3);
    repeat (24) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", tx_valid, 0);
    chk("t6_data", tx_data, 0);
    chk("t6_vldb_last", {tx_vldb, tx_last}, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cnts", {sent_cnt, ok_cnt | err_cnt}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_run(16'd1, 1);
    wait_done("t6_done", 2000);
    chk("t6_sent", sent_cnt, 1);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
